// File: rtl/vga_timing_pkg.sv
// 1280x800@60 raster timing shared by scan-out, renderer and game logic.
// Also holds the coordinate widths and the bundle carried by the delay line.
package vga_timing_pkg;

  localparam int H_ACTIVE = 1280;
  localparam int H_FP     = 72;
  localparam int H_SYNC   = 128;
  localparam int H_BP     = 200;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 800;
  localparam int V_FP     = 3;
  localparam int V_SYNC   = 6;
  localparam int V_BP     = 22;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic H_POL = 1'b0;
  localparam logic V_POL = 1'b1;

  localparam int PIPE_LAT = 2;

  localparam int X_W = 11;
  localparam int Y_W = 10;

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
  } tim_t;

endpackage

// File: rtl/vga_scan_if.sv
// Scan-out bundle: coordinates out to the renderer, colour back,
// and the VGA pin group plus frame tick.
interface vga_scan_if;
  import vga_timing_pkg::*;

  logic [X_W-1:0] draw_x;
  logic [Y_W-1:0] draw_y;
  logic [3:0]     r;
  logic [3:0]     g;
  logic [3:0]     b;
  logic [3:0]     vga_r;
  logic [3:0]     vga_g;
  logic [3:0]     vga_b;
  logic           vga_hs;
  logic           vga_vs;
  logic           frame_tick;

  modport master (
    output draw_x, draw_y,
    input  r, g, b,
    output vga_r, vga_g, vga_b,
    output vga_hs, vga_vs, frame_tick
  );

  modport slave (
    input  draw_x, draw_y,
    output r, g, b,
    input  vga_r, vga_g, vga_b,
    input  vga_hs, vga_vs, frame_tick
  );

endinterface

// File: rtl/vga_scan_out_sig_delay.sv
// Depth-N, width-W shift register with async active-low clear.
// Aligns raster timing bits with the renderer's colour latency.
module sig_delay #(
  parameter int W = 3,
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] sr_q [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < N; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign q_o = sr_q[N-1];

endmodule

// File: rtl/vga_scan_out.sv
// Raster counters, timing alignment to renderer latency and
// registered VGA pin stage with a once-per-frame tick.
module vga_scan_out
  import vga_timing_pkg::*;
#(
  parameter int   HACTIVE = H_ACTIVE,
  parameter int   HFP     = H_FP,
  parameter int   HSYNC   = H_SYNC,
  parameter int   HBP     = H_BP,
  parameter int   VACTIVE = V_ACTIVE,
  parameter int   VFP     = V_FP,
  parameter int   VSYNC   = V_SYNC,
  parameter int   VBP     = V_BP,
  parameter logic HPOL    = H_POL,
  parameter logic VPOL    = V_POL,
  parameter int   LAT     = PIPE_LAT
) (
  input  logic       clk,
  input  logic       rst_n,
  vga_scan_if.master bus
);

  localparam logic [X_W-1:0] X_ACT  =
    X_W'(HACTIVE);
  localparam logic [X_W-1:0] HS_BEG =
    X_W'(HACTIVE + HFP);
  localparam logic [X_W-1:0] HS_END =
    X_W'(HACTIVE + HFP + HSYNC - 1);
  localparam logic [X_W-1:0] X_LAST =
    X_W'(HACTIVE + HFP + HSYNC + HBP - 1);

  localparam logic [Y_W-1:0] Y_ACT  =
    Y_W'(VACTIVE);
  localparam logic [Y_W-1:0] VS_BEG =
    Y_W'(VACTIVE + VFP);
  localparam logic [Y_W-1:0] VS_END =
    Y_W'(VACTIVE + VFP + VSYNC - 1);
  localparam logic [Y_W-1:0] Y_LAST =
    Y_W'(VACTIVE + VFP + VSYNC + VBP - 1);

  logic [X_W-1:0] h_q, h_d;
  logic [Y_W-1:0] v_q, v_d;
  tim_t           raw, dly;
  logic [11:0]    rgb_q, rgb_d;
  logic           hs_q, hs_d;
  logic           vs_q, vs_d;
  logic           tick_q, tick_d;

  always_comb begin
    h_d = (h_q == X_LAST) ? '0 : h_q + 1'b1;
    v_d = v_q;
    if (h_q == X_LAST)
      v_d = (v_q == Y_LAST) ? '0 : v_q + 1'b1;

    raw     = '0;
    raw.act = (h_q < X_ACT) && (v_q < Y_ACT);
    raw.hs  = (h_q >= HS_BEG) && (h_q <= HS_END);
    raw.vs  = (v_q >= VS_BEG) && (v_q <= VS_END);

    // colour is only trusted while the aligned active bit is set
    rgb_d  = dly.act ? {bus.r, bus.g, bus.b} : '0;
    hs_d   = dly.hs ? HPOL : ~HPOL;
    vs_d   = dly.vs ? VPOL : ~VPOL;
    tick_d = (h_q == '0) && (v_q == Y_ACT);
  end

  sig_delay #(
    .W ($bits(tim_t)),
    .N (LAT)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (raw),
    .q_o   (dly)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q    <= '0;
      v_q    <= '0;
      rgb_q  <= '0;
      hs_q   <= ~HPOL;
      vs_q   <= ~VPOL;
      tick_q <= 1'b0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      rgb_q  <= rgb_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      tick_q <= tick_d;
    end
  end

  assign bus.draw_x     = h_q;
  assign bus.draw_y     = v_q;
  assign bus.vga_r      = rgb_q[11:8];
  assign bus.vga_g      = rgb_q[7:4];
  assign bus.vga_b      = rgb_q[3:0];
  assign bus.vga_hs     = hs_q;
  assign bus.vga_vs     = vs_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_vga_scan_out.sv
// Bench: full-size raster (PIPE_LAT=2) plus a shrunken raster (LAT=1,
// inverted hsync) checked every cycle against a position-based model.
module tb_vga_scan_out;
  import vga_timing_pkg::*;

  localparam int   B_HA = 16, B_HF = 3, B_HS = 4, B_HB = 5;
  localparam int   B_VA = 10, B_VF = 2, B_VS = 3, B_VB = 2;
  localparam logic B_HP = 1'b1;
  localparam int   B_LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n_a, rst_n_b;
  vga_scan_if if_a ();
  vga_scan_if if_b ();

  vga_scan_out u_a (
    .clk   (clk),
    .rst_n (rst_n_a),
    .bus   (if_a)
  );

  vga_scan_out #(
    .HACTIVE (B_HA), .HFP (B_HF), .HSYNC (B_HS), .HBP (B_HB),
    .VACTIVE (B_VA), .VFP (B_VF), .VSYNC (B_VS), .VBP (B_VB),
    .HPOL (B_HP), .VPOL (V_POL), .LAT (B_LAT)
  ) u_b (
    .clk   (clk),
    .rst_n (rst_n_b),
    .bus   (if_b)
  );

  int ha[2]  = '{H_ACTIVE, B_HA};
  int hfp[2] = '{H_FP, B_HF};
  int hsw[2] = '{H_SYNC, B_HS};
  int hbp[2] = '{H_BP, B_HB};
  int va[2]  = '{V_ACTIVE, B_VA};
  int vfp[2] = '{V_FP, B_VF};
  int vsw[2] = '{V_SYNC, B_VS};
  int vbp[2] = '{V_BP, B_VB};
  bit hpol[2] = '{H_POL, B_HP};
  bit vpol[2] = '{V_POL, V_POL};
  int lat[2] = '{PIPE_LAT, B_LAT};

  int          kc[2];
  logic [11:0] hist [2][8];
  bit          go = 1'b0;
  int          checks = 0;
  int          errors = 0;

  function automatic int ht(int i);
    return ha[i] + hfp[i] + hsw[i] + hbp[i];
  endfunction

  function automatic int vt(int i);
    return va[i] + vfp[i] + vsw[i] + vbp[i];
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s got %0h want %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // renderer model: colour for the coordinate issued lat clocks ago
  task automatic drive(int i);
    int p, c, cx, cy;
    logic [11:0] v;
    p = kc[i];
    v = 12'($urandom);
    if (p >= lat[i]) begin
      c  = p - lat[i];
      cx = c % ht(i);
      cy = (c / ht(i)) % vt(i);
      if (cx < ha[i] && cy < va[i]) v[11:8] = cx[3:0];
      else v = 12'hFFF;
    end
    hist[i][p % 8] = v;
    if (i == 0) begin
      if_a.r = v[11:8]; if_a.g = v[7:4]; if_a.b = v[3:0];
    end else begin
      if_b.r = v[11:8]; if_b.g = v[7:4]; if_b.b = v[3:0];
    end
  endtask

  task automatic cmp_dut(int i);
    logic [10:0] dx;
    logic [9:0]  dy;
    logic [11:0] rgb, ergb;
    logic        hs, vs, tk, rn, ehs, evs, etk;
    int          p, c, cx, cy, ex, ey;
    if (i == 0) begin
      dx = if_a.draw_x; dy = if_a.draw_y;
      rgb = {if_a.vga_r, if_a.vga_g, if_a.vga_b};
      hs = if_a.vga_hs; vs = if_a.vga_vs;
      tk = if_a.frame_tick; rn = rst_n_a;
    end else begin
      dx = if_b.draw_x; dy = if_b.draw_y;
      rgb = {if_b.vga_r, if_b.vga_g, if_b.vga_b};
      hs = if_b.vga_hs; vs = if_b.vga_vs;
      tk = if_b.frame_tick; rn = rst_n_b;
    end
    ex = 0; ey = 0; ergb = '0; etk = 1'b0;
    ehs = ~hpol[i]; evs = ~vpol[i];
    if (rn) begin
      p  = kc[i];
      ex = p % ht(i);
      ey = (p / ht(i)) % vt(i);
      if (p >= lat[i] + 1) begin
        c  = p - lat[i] - 1;
        cx = c % ht(i);
        cy = (c / ht(i)) % vt(i);
        if (cx < ha[i] && cy < va[i]) ergb = hist[i][(p - 1) % 8];
        if (cx >= ha[i] + hfp[i] && cx < ha[i] + hfp[i] + hsw[i])
          ehs = hpol[i];
        if (cy >= va[i] + vfp[i] && cy < va[i] + vfp[i] + vsw[i])
          evs = vpol[i];
      end
      if (p >= 1) begin
        c   = p - 1;
        etk = (c % ht(i) == 0) && ((c / ht(i)) % vt(i) == va[i]);
      end
    end
    chk(i == 0 ? "a_draw_x" : "b_draw_x", dx, ex);
    chk(i == 0 ? "a_draw_y" : "b_draw_y", dy, ey);
    chk(i == 0 ? "a_rgb" : "b_rgb", rgb, ergb);
    chk(i == 0 ? "a_hs" : "b_hs", hs, ehs);
    chk(i == 0 ? "a_vs" : "b_vs", vs, evs);
    chk(i == 0 ? "a_tick" : "b_tick", tk, etk);
  endtask

  always @(negedge clk) begin
    if (go) begin
      cmp_dut(0);
      cmp_dut(1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rst_n_a) kc[0]++;
    if (rst_n_b) kc[1]++;
    drive(0);
    drive(1);
  endtask

  int hs_low = 0, first_low = -1;
  int vs_hi = 0, ticks = 0, first_tick = -1;

  initial begin
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    kc[0] = 0;
    kc[1] = 0;
    drive(0);
    drive(1);
    go = 1'b1;
    repeat (10) step();
    chk("lit_rst_x", if_a.draw_x, 0);
    chk("lit_rst_y", if_a.draw_y, 0);
    chk("lit_rst_rgb", {if_a.vga_r, if_a.vga_g, if_a.vga_b}, 0);
    chk("lit_rst_hs", if_a.vga_hs, 1);
    chk("lit_rst_vs", if_a.vga_vs, 0);
    chk("lit_rst_tick", if_a.frame_tick, 0);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;

    for (int n = 0; n < 4060; n++) begin
      step();
      if (kc[0] == 1) chk("lit_x_release", if_a.draw_x, 1);
      if (kc[0] <= 1680 && if_a.vga_hs === 1'b0) begin
        hs_low++;
        if (first_low < 0) first_low = kc[0];
      end
      if (kc[1] < 1428) begin
        if (if_b.vga_vs === 1'b1) vs_hi++;
        if (if_b.frame_tick === 1'b1) begin
          ticks++;
          if (first_tick < 0) first_tick = kc[1];
        end
      end
      if (kc[0] == 8) chk("lit_r_x5", if_a.vga_r, 5);
      if (kc[0] == 1282) chk("lit_r_x1279", if_a.vga_r, 15);
      if (kc[0] == 1283)
        chk("lit_rgb_x1280",
            {if_a.vga_r, if_a.vga_g, if_a.vga_b}, 0);
      if (kc[0] == 1680) chk("lit_wrap_y", if_a.draw_y, 1);
    end
    chk("lit_hs_low_len", hs_low, 128);
    chk("lit_hs_first", first_low, 1355);
    chk("lit_b_vs_len", vs_hi, 252);
    chk("lit_b_ticks", ticks, 3);
    chk("lit_b_tick_at", first_tick, 281);
    chk("lit_pre_rst_x", if_a.draw_x, 700);

    #2;
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    kc[0] = 0;
    kc[1] = 0;
    #1;
    chk("lit_mid_rst_x", if_a.draw_x, 0);
    chk("lit_mid_rst_hs", if_a.vga_hs, 1);
    chk("lit_b_mid_rst_y", if_b.draw_y, 0);
    chk("lit_b_mid_rst_hs", if_b.vga_hs, 0);
    repeat (3) step();
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;

    for (int n = 0; n < 2000; n++) begin
      step();
      if (kc[0] == 1) chk("lit_restart_x", if_a.draw_x, 1);
      if (kc[0] == 2)
        chk("lit_restart_blank",
            {if_a.vga_r, if_a.vga_g, if_a.vga_b}, 0);
    end

    go = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
